// File: rtl/lsu_credit_arbiter_pkg.sv
// Shared helpers for the LSU credit arbiter slice.
// Holds no types; only width helpers used by parameter defaults.
package lsu_credit_arbiter_pkg;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lsu_credit_arbiter_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the last grant.
// The pointer register moves only when the caller accepts the grant.
module rr_arbiter
  import lsu_credit_arbiter_pkg::*;
#(
  parameter  int NUM_REQS = 4,
  localparam int SEL_W    = idx_width(NUM_REQS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                enable,
  output logic [NUM_REQS-1:0] grant_onehot,
  output logic [SEL_W-1:0]    grant_index,
  output logic                grant_valid
);

  logic [SEL_W-1:0] r_last;

  always_comb begin
    grant_onehot = '0;
    grant_index  = '0;
    grant_valid  = 1'b0;
    for (int off = 1; off <= NUM_REQS; off++) begin
      if (!grant_valid && requests[(int'(r_last) + off) % NUM_REQS]) begin
        grant_valid = 1'b1;
        grant_index = SEL_W'((int'(r_last) + off) % NUM_REQS);
        grant_onehot[(int'(r_last) + off) % NUM_REQS] = 1'b1;
      end
    end
  end

  // Reset value makes requester 0 the first in priority order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= SEL_W'(NUM_REQS - 1);
    end else if (enable && grant_valid) begin
      r_last <= grant_index;
    end
  end

endmodule

// File: rtl/lsu_credit_arbiter.sv
// Credit-gated round-robin front end for one LSU slice: one grant per
// cycle into a registered output stage, one credit back per response.
module lsu_credit_arbiter
  import lsu_credit_arbiter_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_CREDITS = 8,
  parameter int SEL_WIDTH   = idx_width(NUM_REQS),
  parameter int CNT_WIDTH   = $clog2(MAX_CREDITS + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           out_valid,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [SEL_WIDTH-1:0]           out_sel,
  input  logic                           out_ready,
  input  logic                           rsp_done,
  output logic [CNT_WIDTH-1:0]           credits,
  output logic                           idle
);

  localparam logic [CNT_WIDTH-1:0] LP_MAX = CNT_WIDTH'(MAX_CREDITS);
  localparam logic [CNT_WIDTH-1:0] LP_ONE = CNT_WIDTH'(1);

  logic                  w_can_issue;
  logic                  w_grant;
  logic                  w_arb_valid;
  logic [NUM_REQS-1:0]   w_onehot;
  logic [SEL_WIDTH-1:0]  w_idx;

  logic [CNT_WIDTH-1:0]  r_credits;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_sel;

  // Reset term keeps req_ready low for the whole time reset is held.
  assign w_can_issue = !reset && (r_credits != '0) && (!r_out_valid || out_ready);
  assign w_grant     = w_can_issue && w_arb_valid;
  assign req_ready   = w_can_issue ? w_onehot : '0;

  rr_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_rr_arbiter (
    .clk          (clk),
    .reset        (reset),
    .requests     (req_valid),
    .enable       (w_can_issue),
    .grant_onehot (w_onehot),
    .grant_index  (w_idx),
    .grant_valid  (w_arb_valid)
  );

  // Grant and response in the same cycle cancel; an extra response at full
  // credit is dropped so the counter never exceeds MAX_CREDITS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_credits <= LP_MAX;
    end else if (w_grant && !rsp_done) begin
      r_credits <= r_credits - LP_ONE;
    end else if (!w_grant && rsp_done && (r_credits != LP_MAX)) begin
      r_credits <= r_credits + LP_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= req_data[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
      r_out_sel   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign credits   = r_credits;
  assign idle      = (r_credits == LP_MAX) && !r_out_valid;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_done && (r_credits == LP_MAX)))
        else $error("rsp_done returned a credit while all credits were available");
    end
  end
`endif

endmodule

// File: tb/tb_lsu_credit_arbiter.sv
// Randomized and directed bench for lsu_credit_arbiter with a
// transaction-level model of pointer, credits and output stage.
module tb_lsu_credit_arbiter;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int MAX = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_sel;
  logic            out_ready;
  logic            rsp_done;
  logic [3:0]      credits;
  logic            idle;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          m_last;
  int          m_cred;
  bit          m_ov;
  logic [63:0] m_od;
  int          m_os;
  logic [63:0] hold_d;

  lsu_credit_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .rsp_done  (rsp_done),
    .credits   (credits),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1;
    m_cred = MAX;
    m_ov   = 1'b0;
    m_od   = '0;
    m_os   = 0;
  endtask

  // Who wins this cycle per the round-robin rule, or -1 for no grant.
  function automatic int model_winner();
    bit can;
    can = (m_cred != 0) && (!m_ov || out_ready);
    if (!can) return -1;
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // Called at posedge+1; drives inputs, checks at negedge, advances model at posedge.
  task automatic step(input logic [N-1:0] rv, input logic ordy, input logic rsp);
    int w;
    logic [N-1:0] exp_rdy;
    req_valid = rv;
    out_ready = ordy;
    rsp_done  = rsp;
    for (int k = 0; k < N; k++) req_data[k*DW +: DW] = {$urandom, $urandom};
    @(negedge clk);
    w = model_winner();
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("out_data", out_data, m_od);
      chk("out_sel", 64'(out_sel), 64'(m_os));
    end
    chk("credits", 64'(credits), 64'(m_cred));
    chk("idle", 64'(idle), 64'((m_cred == MAX) && !m_ov));
    @(posedge clk);
    if (w >= 0) begin
      m_ov = 1'b1;
      m_od = req_data[w*DW +: DW];
      m_os = w;
      m_last = w;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    m_cred = m_cred + (rsp ? 1 : 0) - ((w >= 0) ? 1 : 0);
    if (m_cred > MAX) m_cred = MAX;
    #1;
  endtask

  // Asserts reset asynchronously, checks reset values immediately, releases after next edge.
  task automatic do_reset();
    reset = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    rsp_done  = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_credits", 64'(credits), 64'd8);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    rsp_done = 1'b0;
    do_reset();

    // Full request pressure: grants 0,1,2,3,0,... until credits run out.
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, 1'b1, 1'b0);
      if (i < 8) begin
        chk("order_sel", 64'(out_sel), 64'(i % 4));
        chk("order_credits", 64'(credits), 64'(7 - i));
      end
    end
    chk("drained_credits", 64'(credits), 64'd0);
    chk("drained_valid", 64'(out_valid), 64'd0);

    // One response at zero credit allows exactly one grant the next cycle.
    step(4'b1111, 1'b1, 1'b1);
    chk("rsp_credit_back", 64'(credits), 64'd1);
    step(4'b1111, 1'b1, 1'b0);
    chk("rsp_grant_sel", 64'(out_sel), 64'd0);
    chk("rsp_grant_cred", 64'(credits), 64'd0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rsp_single", 64'(out_valid), 64'd0);

    // Refill to 4, then stall the output for 5 cycles.
    for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    chk("stall_sel0", 64'(out_sel), 64'd1);
    chk("stall_cred0", 64'(credits), 64'd3);
    hold_d = m_od;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sel", 64'(out_sel), 64'd1);
      chk("stall_data", out_data, hold_d);
      chk("stall_cred", 64'(credits), 64'd3);
    end

    // Grant plus response every cycle keeps credits flat.
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, 1'b1, 1'b1);
      chk("flat_cred", 64'(credits), 64'd3);
      chk("flat_sel", 64'(out_sel), 64'((2 + i) % 4));
    end

    // Pointer rotates from the most recent grant.
    step(4'b0100, 1'b1, 1'b0);
    chk("rot_sel2", 64'(out_sel), 64'd2);
    step(4'b1001, 1'b1, 1'b0);
    chk("rot_sel3", 64'(out_sel), 64'd3);
    step(4'b1001, 1'b1, 1'b0);
    chk("rot_sel0", 64'(out_sel), 64'd0);
    chk("rot_cred", 64'(credits), 64'd0);
    for (int i = 0; i < 8; i++) step(4'b0000, 1'b1, 1'b1);
    chk("refill_idle", 64'(idle), 64'd1);

    // Random traffic; responses only while credits are outstanding.
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), ($urandom_range(0, 3) != 0),
           (m_cred < MAX) && ($urandom_range(0, 2) == 0));
    end

    // Reset mid-stream with an output in flight and credits at 2.
    do_reset();
    for (int i = 0; i < 6; i++) step(4'b1111, 1'b1, 1'b0);
    chk("pre_rst_cred", 64'(credits), 64'd2);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #1;
    do_reset();
    step(4'b1111, 1'b1, 1'b0);
    chk("post_rst_sel", 64'(out_sel), 64'd0);
    chk("post_rst_cred", 64'(credits), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
